// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states and widths for the sequential multiplier.
package mult_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PROD_W = 2*WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/add8_stage.sv
// add8_stage: combinational ripple-carry adder with carry-in tied low.
module add8_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = c[WIDTH];
endmodule

// File: rtl/seq_mult8.sv
// seq_mult8: shift-and-add unsigned multiplier, one partial product per clock.
// Build with MULT_ZERO_SKIP_EN to finish immediately when either operand is zero.
module seq_mult8
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, acc_q, acc_d, q_q, q_d, addend, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic co, accept, run, last, skip;
`ifdef MULT_ZERO_SKIP_EN
  assign skip = (A == '0) || (B == '0);
`else
  assign skip = 1'b0;
`endif
  assign addend = q_q[0] ? m_q : '0;
  add8_stage #(.WIDTH(WIDTH)) u_add (
    .a_i  (acc_q),
    .b_i  (addend),
    .sum_o(sum),
    .co_o (co)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end
  // start is honoured in IDLE and DONE alike, which gives back-to-back operation
  always_comb begin
    run     = state_q == RUN;
    accept  = start && !run;
    last    = run && cnt_q == CNT_W'(WIDTH-1);
    state_d = accept ? (skip ? DONE : RUN) : last ? DONE : run ? RUN : IDLE;
    m_d     = accept ? A : m_q;
    acc_d   = accept ? '0 : run ? {co, sum[WIDTH-1:1]} : acc_q;
    q_d     = accept ? B : run ? {sum[0], q_q[WIDTH-1:1]} : q_q;
    cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    p_d     = (accept && skip) ? '0 : last ? {co, sum, q_q[WIDTH-1:1]} : p_q;
  end
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  assign P = p_q;
endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8: directed and random operands checked against plain a*b and cycle counts.
module tb_seq_mult8;
  logic clk = 1'b0, rst, start, busy, done;
  logic [7:0] A, B;
  logic [15:0] P, exp_p;
  int checks = 0, errors = 0;
  seq_mult8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .P    (P)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  // Issue a start and follow the operation to its done cycle; returns in that cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke);
    int n, bc, lat;
    logic [15:0] want;
    want = 16'(a) * 16'(b);
    lat = 9;
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || b == 0) lat = 1;
`endif
    start = 1'b1;
    A = a;
    B = b;
    step();
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    n = 1;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      chk("p_hold", P, exp_p);
      if (n == poke) begin
        start = 1'b1;
        A = 8'd1;
        B = 8'd1;
      end else start = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("latency", n, lat);
    chk("busy_cycles", bc, lat - 1);
    chk("busy_in_done", busy, 0);
    chk("product", P, want);
    exp_p = want;
  endtask
  initial begin
    int dc;
    logic [7:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    exp_p = '0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", P, 0);
    rst = 1'b0;
    step();
    run_op(8'd13, 8'd11, 0);
    step();
    run_op(8'd255, 8'd255, 0);
    step();
    run_op(8'd200, 8'd3, 3);
    step();
    chk("ignored_start_idle", busy, 0);
    start = 1'b1;
    A = 8'd77;
    B = 8'd99;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_p", P, 0);
    exp_p = '0;
    dc = 0;
    repeat (12) begin
      step();
      if (done) dc++;
    end
    chk("midrst_no_done", dc, 0);
    run_op(8'd2, 8'd3, 0);
    step();
    rst = 1'b1;
    start = 1'b1;
    A = 8'd9;
    B = 8'd9;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_p", P, 0);
    exp_p = '0;
    step();
    chk("rst_prio_idle", busy, 0);
    run_op(8'd5, 8'd6, 0);
    run_op(8'd7, 8'd8, 0);
    step();
    run_op(8'd0, 8'd200, 0);
    step();
    run_op(8'd200, 8'd0, 0);
    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 1) == 1) step();
      run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
    end
    step();
    chk("final_idle_done", done, 0);
    chk("final_hold_p", P, exp_p);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
